// File: rtl/baud_pkg.sv
// Shared constants for the UART baud-rate generator: rate table, divisor helpers and
// rate-switch state encoding.
package baud_pkg;

  localparam int NUM_RATES_DEF = 4;
  localparam longint RATES [4] = '{64'd9600, 64'd19200, 64'd57600, 64'd115200};

  localparam int SEL_9600   = 0;
  localparam int SEL_19200  = 1;
  localparam int SEL_57600  = 2;
  localparam int SEL_115200 = 3;

  typedef enum logic {
    RS_IDLE,
    RS_PENDING
  } rs_state_e;

  function automatic longint calc_div(input longint clk, input longint rate, input longint os);
    return clk / (rate * os);
  endfunction

  // Residue in sixteenths, rounded to nearest; clamped so it always fits 4 bits.
  function automatic longint calc_frac(input longint clk, input longint rate, input longint os);
    longint d;
    longint rem;
    longint f;
    d   = rate * os;
    rem = clk - (clk / d) * d;
    f   = (32 * rem + d) / (2 * d);
    if (f > 15) f = 15;
    return f;
  endfunction

endpackage

// File: rtl/baud_divider.sv
// Loadable down-counter emitting the registered oversample tick. With BAUD_FRAC_DIV_EN a
// 4-bit accumulator stretches one rx period by a cycle on each carry.
module baud_divider #(
  parameter int               DIV_W    = 16,
  parameter logic [DIV_W-1:0] INIT_CNT = '0
) (
  input  logic             src_clk,
  input  logic             rst,
  input  logic             en,
`ifdef BAUD_FRAC_DIV_EN
  input  logic             clr,
  input  logic [3:0]       frac_val,
`endif
  input  logic [DIV_W-1:0] div_val,
  output logic             wrap,
  output logic             rx_tick
);

  logic [DIV_W-1:0] cnt_reg;
  logic [DIV_W-1:0] reload;

  assign wrap = en && (cnt_reg == '0);

`ifdef BAUD_FRAC_DIV_EN
  logic [3:0] acc_reg;
  logic [4:0] acc_sum;

  assign acc_sum = {1'b0, acc_reg} + {1'b0, frac_val};
  assign reload  = (acc_sum[4] && !clr) ? div_val : div_val - 1'b1;

  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (!en || clr) begin
      acc_reg <= '0;
    end else if (wrap) begin
      acc_reg <= acc_sum[3:0];
    end
  end
`else
  assign reload = div_val - 1'b1;
`endif

  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= INIT_CNT;
      rx_tick <= 1'b0;
    end else begin
      rx_tick <= wrap;
      if (!en) begin
        cnt_reg <= div_val - 1'b1;
      end else if (wrap) begin
        cnt_reg <= reload;
      end else begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/baud_gen.sv
// UART baud generator: shared divider, oversample counter, Uart_clk and glitch-free rate
// switching at bit boundaries. Define BAUD_FRAC_DIV_EN for the fractional divider.
module baud_gen
  import baud_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int NUM_RATES  = NUM_RATES_DEF,
  parameter int SEL_W      = 2,
  parameter int DIV_W      = 16
) (
  input  logic             src_clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SEL_W-1:0] Prescaler_sel,
  output logic             rx_tick,
  output logic             tx_tick,
  output logic             Uart_clk,
  output logic             busy,
  output logic             sel_err
);

  localparam int              OS_W      = $clog2(OVERSAMPLE);
  localparam int              NUM_SLOTS = 2 ** SEL_W;
  localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF   = OS_W'(OVERSAMPLE / 2);
  localparam longint          INIT_DIV  = calc_div(CLK_FREQ, RATES[0], OVERSAMPLE);

  if (OVERSAMPLE < 2 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("baud_gen: OVERSAMPLE must be even and >= 2");
  end
  if (NUM_RATES < 1 || NUM_RATES > NUM_RATES_DEF || NUM_SLOTS < NUM_RATES) begin : g_bad_sel
    $error("baud_gen: NUM_RATES out of range for rate table or SEL_W");
  end

  // Unused select codes alias rate 0 so the table index never runs off the end.
  logic [DIV_W-1:0] div_tab [NUM_SLOTS];
`ifdef BAUD_FRAC_DIV_EN
  logic [3:0] frac_tab [NUM_SLOTS];
`endif

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_rate
    localparam int     RI    = (gi < NUM_RATES) ? gi : 0;
    localparam longint DIV_L = calc_div(CLK_FREQ, RATES[RI], OVERSAMPLE);
    if (DIV_L < 1 || DIV_L >= (longint'(1) << DIV_W)) begin : g_bad_div
      $error("baud_gen: divisor out of range for DIV_W");
    end
    assign div_tab[gi] = DIV_W'(DIV_L);
`ifdef BAUD_FRAC_DIV_EN
    assign frac_tab[gi] = 4'(calc_frac(CLK_FREQ, RATES[RI], OVERSAMPLE));
`endif
  end

  rs_state_e        state_reg;
  logic [SEL_W-1:0] active_reg, pending_reg, active_next, pending_next;
  logic [OS_W-1:0]  os_cnt_reg, os_cnt_next;
  logic             rx_wrap, bit_end, sel_valid;
  logic             tx_tick_reg, uart_clk_reg, sel_err_reg;

  assign sel_valid = 32'(Prescaler_sel) < 32'(NUM_RATES);

  always_comb begin
    bit_end      = rx_wrap && (os_cnt_reg == OS_LAST);
    active_next  = (!en || bit_end) ? pending_reg : active_reg;
    pending_next = (sel_valid && (Prescaler_sel != pending_reg)) ? Prescaler_sel : pending_reg;
    os_cnt_next  = os_cnt_reg;
    if (!en) begin
      os_cnt_next = '0;
    end else if (rx_wrap) begin
      os_cnt_next = bit_end ? '0 : os_cnt_reg + 1'b1;
    end
  end

`ifdef BAUD_FRAC_DIV_EN
  logic rate_switch;
  assign rate_switch = bit_end && (pending_reg != active_reg);
`endif

  // The divider reloads from the rate that will be active after this edge.
  baud_divider #(
    .DIV_W    (DIV_W),
    .INIT_CNT (DIV_W'(INIT_DIV - 1))
  ) u_div (
    .src_clk  (src_clk),
    .rst      (rst),
    .en       (en),
`ifdef BAUD_FRAC_DIV_EN
    .clr      (rate_switch),
    .frac_val (frac_tab[active_next]),
`endif
    .div_val  (div_tab[active_next]),
    .wrap     (rx_wrap),
    .rx_tick  (rx_tick)
  );

  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) begin
      state_reg    <= RS_IDLE;
      active_reg   <= '0;
      pending_reg  <= '0;
      os_cnt_reg   <= '0;
      tx_tick_reg  <= 1'b0;
      uart_clk_reg <= 1'b0;
      sel_err_reg  <= 1'b0;
    end else begin
      active_reg   <= active_next;
      pending_reg  <= pending_next;
      os_cnt_reg   <= os_cnt_next;
      tx_tick_reg  <= bit_end;
      uart_clk_reg <= en && (os_cnt_next < OS_HALF);
      sel_err_reg  <= !sel_valid;
      state_reg    <= (pending_next != active_next) ? RS_PENDING : RS_IDLE;
    end
  end

  assign tx_tick  = tx_tick_reg;
  assign Uart_clk = uart_clk_reg;
  assign sel_err  = sel_err_reg;
  assign busy     = (state_reg == RS_PENDING);

endmodule

// File: tb/tb_baud_gen.sv
// Directed bench for baud_gen at 1.8432 MHz (divisors 12/6/2/1), a 3-rate instance for
// invalid selects, and a 50 MHz instance for the fractional divider when enabled.
module tb_baud_gen;
  import baud_pkg::*;

  localparam int W_RX  = 0;
  localparam int W_TX  = 1;
  localparam int W_ULO = 2;
  localparam int W_UHI = 3;
  localparam int W_RX3 = 4;
  localparam int W_RXF = 5;

  logic       src_clk = 1'b0;
  logic       rst     = 1'b1;
  logic       en      = 1'b0;
  logic       en3     = 1'b0;
  logic [1:0] sel     = 2'd0;
  logic [1:0] sel3    = 2'd0;
  logic       rx_tick, tx_tick, Uart_clk, busy, sel_err;
  logic       rx3, tx3, uclk3, busy3, sel_err3;

  int vectors     = 0;
  int miscompares = 0;

  always #5 src_clk = ~src_clk;

  baud_gen #(
    .CLK_FREQ(1_843_200), .OVERSAMPLE(16), .NUM_RATES(4), .SEL_W(2), .DIV_W(16)
  ) dut (
    .src_clk(src_clk), .rst(rst), .en(en), .Prescaler_sel(sel),
    .rx_tick(rx_tick), .tx_tick(tx_tick), .Uart_clk(Uart_clk), .busy(busy), .sel_err(sel_err)
  );

  baud_gen #(
    .CLK_FREQ(1_843_200), .OVERSAMPLE(16), .NUM_RATES(3), .SEL_W(2), .DIV_W(16)
  ) dut3 (
    .src_clk(src_clk), .rst(rst), .en(en3), .Prescaler_sel(sel3),
    .rx_tick(rx3), .tx_tick(tx3), .Uart_clk(uclk3), .busy(busy3), .sel_err(sel_err3)
  );

`ifdef BAUD_FRAC_DIV_EN
  logic       en_f  = 1'b0;
  logic [1:0] sel_f = 2'(SEL_115200);
  logic       rxf, txf, uclkf, busyf, sel_errf;

  baud_gen #(
    .CLK_FREQ(50_000_000), .OVERSAMPLE(16), .NUM_RATES(4), .SEL_W(2), .DIV_W(16)
  ) dut_f (
    .src_clk(src_clk), .rst(rst), .en(en_f), .Prescaler_sel(sel_f),
    .rx_tick(rxf), .tx_tick(txf), .Uart_clk(uclkf), .busy(busyf), .sel_err(sel_errf)
  );
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    $display("%s: observed %0d expected %0d", tag, obs, exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int id);
    case (id)
      W_RX:    return rx_tick;
      W_TX:    return tx_tick;
      W_ULO:   return !Uart_clk;
      W_UHI:   return Uart_clk;
      W_RX3:   return rx3;
`ifdef BAUD_FRAC_DIV_EN
      W_RXF:   return rxf;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Negedges until the watched condition is seen; -1 when the bound expires.
  task automatic wait_sig(input int id, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge src_clk);
      if (sig(id)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic expect_wait(input string tag, input int id, input int exp);
    int n;
    wait_sig(id, exp + 64, n);
    check(tag, n, exp);
  endtask

  initial begin
    int cnt;
    int n;
    int sum;

    repeat (3) @(negedge src_clk);
    check("rst_rx", rx_tick, 0);
    check("rst_tx", tx_tick, 0);
    check("rst_uart", Uart_clk, 0);
    check("rst_busy", busy, 0);
    check("rst_sel_err", sel_err, 0);

    // Invalid select on the 3-rate instance
    rst  = 1'b0;
    en3  = 1'b1;
    sel3 = 2'd3;
    @(negedge src_clk);
    check("err_pulse", sel_err3, 1);
    check("err_busy", busy3, 0);
    @(negedge src_clk);
    check("err_hold", sel_err3, 1);
    expect_wait("err_rx_first", W_RX3, 10);
    sel3 = 2'(SEL_9600);
    @(negedge src_clk);
    check("err_clear", sel_err3, 0);
    expect_wait("err_rx_period", W_RX3, 11);
    en3 = 1'b0;

    // Rate 0: DIV 12, bit 192 cycles
    en = 1'b1;
    expect_wait("rx_first", W_RX, 12);
    check("uart_hi_early", Uart_clk, 1);
    expect_wait("rx_period", W_RX, 12);
    expect_wait("tx_first", W_TX, 168);
    check("tx_rx_coinc", rx_tick, 1);
    expect_wait("tx_period", W_TX, 192);
    expect_wait("uart_high_len", W_ULO, 96);
    expect_wait("uart_low_len", W_UHI, 96);
    check("uart_tx_align", tx_tick, 1);

    // Switch 0 -> 3 at cycle 50 of a bit
    repeat (50) @(negedge src_clk);
    check("busy_idle", busy, 0);
    sel = 2'(SEL_115200);
    @(negedge src_clk);
    check("busy_set", busy, 1);
    expect_wait("sw_tx", W_TX, 141);
    check("busy_drop", busy, 0);
    expect_wait("fast_rx1", W_RX, 1);
    expect_wait("fast_rx2", W_RX, 1);
    expect_wait("fast_tx", W_TX, 14);
    expect_wait("fast_uart_hi", W_ULO, 8);
    expect_wait("fast_uart_lo", W_UHI, 8);

    // 3 -> 1 -> 2 inside one bit: only rate 2 lands
    sel = 2'(SEL_19200);
    @(negedge src_clk);
    check("last_busy1", busy, 1);
    sel = 2'(SEL_57600);
    @(negedge src_clk);
    check("last_busy2", busy, 1);
    expect_wait("last_tx", W_TX, 14);
    check("last_busy_drop", busy, 0);
    expect_wait("r2_rx", W_RX, 2);
    expect_wait("r2_tx", W_TX, 30);

    // Request back to the active rate cancels
    sel = 2'(SEL_9600);
    @(negedge src_clk);
    check("cancel_busy", busy, 1);
    sel = 2'(SEL_57600);
    @(negedge src_clk);
    check("cancel_idle", busy, 0);
    expect_wait("cancel_tx", W_TX, 30);

    // Drop enable at os_cnt = 5, then resume at the same rate
    repeat (11) @(negedge src_clk);
    check("pre_off_uart", Uart_clk, 1);
    en = 1'b0;
    @(negedge src_clk);
    check("off_rx", rx_tick, 0);
    check("off_uart", Uart_clk, 0);
    cnt = 0;
    repeat (6) begin
      @(negedge src_clk);
      cnt += int'(rx_tick) + int'(tx_tick) + int'(Uart_clk);
    end
    check("off_quiet", cnt, 0);
    en = 1'b1;
    expect_wait("re_rx", W_RX, 2);
    expect_wait("re_tx", W_TX, 30);

    // Rate change while disabled takes one cycle
    en  = 1'b0;
    sel = 2'(SEL_115200);
    @(negedge src_clk);
    check("dis_busy", busy, 1);
    @(negedge src_clk);
    check("dis_busy_1cyc", busy, 0);
    en = 1'b1;
    expect_wait("dis_rx", W_RX, 1);
    expect_wait("dis_tx", W_TX, 15);

    // Asynchronous reset mid-bit with a change pending
    sel = 2'(SEL_9600);
    @(negedge src_clk);
    check("pre_rst_busy", busy, 1);
    @(negedge src_clk);
    check("pre_rst_uart", Uart_clk, 1);
    check("pre_rst_rx", rx_tick, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_rx", rx_tick, 0);
    check("arst_uart", Uart_clk, 0);
    check("arst_busy", busy, 0);
    @(negedge src_clk);
    rst = 1'b0;
    expect_wait("post_rst_rx", W_RX, 12);

`ifdef BAUD_FRAC_DIV_EN
    // 50 MHz, 115200: DIV 27, FRAC 2
    en_f = 1'b1;
    expect_wait("frac_first", W_RXF, 27);
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      wait_sig(W_RXF, 64, n);
      sum += n;
    end
    check("frac_16_periods", sum, 434);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
